mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage; responder to the MDU control bundle (start, move-to, move-from, 3-bit op select) that the ID/EX register delivers.
- Owns the architectural HI/LO registers and executes mult/multu/div/divu over a fixed number of cycles.
- Exposes busy so the D-stage hazard logic can stall later MDU instructions; serves mfhi/mflo reads combinationally.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high after a mult/multu start (>=1)
- DIV_CYCLES, 10, cycles busy stays high after a div/divu start (>=1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  E-stage instruction is mult/multu/div/divu (StartMDU)
- move_to  input  1  E-stage instruction is mthi/mtlo (MoveToMDU)
- move_from  input  1  E-stage instruction is mfhi/mflo (MoveFromMDU); qualifies rdata only
- sel  input  3  op: 000 mult, 001 multu, 010 div, 011 divu, 100 HI access, 101 LO access; others reserved
- a  input  32  rs operand (forwarded)
- b  input  32  rt operand (forwarded)
- busy  output  1  operation in flight
- rdata  output  32  HI when sel=100, LO when sel=101, else 0; combinational
- hi  output  32  current HI register
- lo  output  32  current LO register

Behaviour:
- Reset (rst=1 at edge): hi=0, lo=0, busy=0, counter=0, pending results=0. Applies mid-operation; the in-flight op is discarded and never commits.
- States: IDLE, RUN. The counter runs only in RUN.
- IDLE + start with sel in {000..011}:
  - At that edge, latch the computed 64-bit result into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from the following cycle.
- RUN: counter decrements each edge. At the edge where counter==1:
  - hi<=pending_hi, lo<=pending_lo; go to IDLE.
  - busy falls the same edge.
  - Net effect: busy high for exactly N cycles; new HI/LO visible in the first cycle busy=0.
- Arithmetic:
  - mult: signed 32x32->64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32->64.
  - div: signed; lo=quotient truncated toward zero; hi=remainder with the dividend's sign. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (b=0): the op still runs full DIV_CYCLES with busy; HI/LO are left unchanged at commit.
- move_to in IDLE, no start:
  - sel=100: hi<=a at that edge.
  - sel=101: lo<=a at that edge.
  - Other sel values: no effect.
- start or move_to while busy=1: ignored; no state change. The hazard unit guarantees this does not occur; the bench checks that it is harmless.
- start and move_to both high: start wins; move_to ignored.
- start with a reserved sel (1xx other than a valid op): ignored.
- rdata:
  - Combinational from the current hi/lo registers, independent of busy. The hazard unit stalls mf* while busy.
  - When move_from=0, rdata still follows sel; consumers gate with move_from.
- Stall condition for the hazard unit is start|busy, computed outside this block.
- No handling for E-stage flush. A flushed bubble arrives with all controls 0, so the block sees no operation.

Test Plan:
- Reset, then start sel=000 a=0xFFFFFFFE (-2) b=3 -> busy high for cycles 1..5 after start; cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged during cycles 1..5.
- start sel=001 a=0xFFFFFFFF b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE. start sel=010 a=-7 b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. start sel=011 a=7 b=2 -> lo=3, hi=1.
- Divide by zero: hi=0x11, lo=0x22, start sel=011 b=0 -> busy 10 cycles; hi=0x11, lo=0x22 afterwards. Overflow: sel=010 a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- move_to sel=100 a=0xDEADBEEF -> next cycle hi=0xDEADBEEF; move_from sel=100 -> rdata=0xDEADBEEF. move_to sel=101 a=5 -> lo=5; rdata with sel=101 is 5.
- During a div (busy=1): start sel=000 a=2 b=3, and move_to sel=101 a=9 -> both ignored; final lo/hi equal the div result; busy length unchanged.
- Assert rst at cycle 3 of a mult -> next cycle busy=0, hi=lo=0; no commit afterwards. start and move_to together in IDLE -> only the multiply takes effect.

Source files
------------

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit owning HI/LO.
// Results are computed at start and committed after a fixed busy window.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        move_to,
  input  logic        move_from,
  input  logic [2:0]  sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic        wr_q, wr_d;

  logic [63:0] prod_s, prod_u;
  logic        sgn, neg_q;
  logic [31:0] ua, ub, ub_nz;
  logic [31:0] uq, ur, dq, dr;

  // Sign-extended operands give the signed product in the low 64 bits.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  assign sgn   = ~sel[0];
  assign ua    = (sgn && a[31]) ? -a : a;
  assign ub    = (sgn && b[31]) ? -b : b;
  assign ub_nz = (ub == 32'd0) ? 32'd1 : ub;
  assign uq    = ua / ub_nz;
  assign ur    = ua % ub_nz;
  assign neg_q = sgn && (a[31] ^ b[31]);
  assign dq    = neg_q ? -uq : uq;
  assign dr    = (sgn && a[31]) ? -ur : ur;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (start && !sel[2]) begin
          state_d = RUN;
          wr_d    = 1'b1;
          unique case (sel[1:0])
            2'b00: {phi_d, plo_d} = prod_s;
            2'b01: {phi_d, plo_d} = prod_u;
            default: begin
              phi_d = dr;
              plo_d = dq;
              wr_d  = (b != 32'd0);
            end
          endcase
          cnt_d = sel[1] ? 32'(DIV_CYCLES)
                         : 32'(MULT_CYCLES);
        end else if (move_to && sel == 3'b100) begin
          hi_d = a;
        end else if (move_to && sel == 3'b101) begin
          lo_d = a;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd1) begin
          state_d = IDLE;
          if (wr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      wr_q    <= wr_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = (sel == 3'b100) ? hi_q :
                 (sel == 3'b101) ? lo_q : 32'd0;

endmodule
